// File: rtl/gpo_shift_out_pkg.sv
// gpo_pkg: shared FSM state type and divider width helper for serial pin drivers
package gpo_pkg;
  typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, LATCH_HI, LATCH_LO} sr_state_t;
  function automatic int div_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/gpo_shift_out_if.sv
// gpo_shift_out_if: parallel word in, 74HC595-style chain pins out
interface gpo_shift_out_if #(parameter int N = 32);
  logic [N-1:0] gpo_data;
  logic         sr_clk;
  logic         sr_data;
  logic         sr_latch;
  logic         sr_oe_n;
  logic         busy;
  modport master (output gpo_data, input sr_clk, sr_data, sr_latch, sr_oe_n, busy);
  modport slave  (input gpo_data, output sr_clk, sr_data, sr_latch, sr_oe_n, busy);
endinterface

// File: rtl/gpo_shift_out_tick.sv
// gpo_sr_tick: phase divider, ticks on the last of CLK_DIV cycles, restartable
module gpo_sr_tick
  import gpo_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int DIV_W = div_w(CLK_DIV);
  logic [DIV_W-1:0] r_cnt;
  assign o_tick = (r_cnt == DIV_W'(CLK_DIV - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/gpo_shift_out.sv
// gpo_shift_out: ships the output word MSB-first to an external shift-register chain
// whenever it differs from the last word shipped, then latches and enables the chain.
module gpo_shift_out
  import gpo_pkg::*;
#(
  parameter int N       = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  gpo_shift_out_if.slave      bus
);
  localparam int CNT_W = div_w(N);
  sr_state_t        r_state, w_nxt;
  logic [N-1:0]     r_shadow, w_shadow_nxt, r_shipped;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             r_init_pending, w_start, w_tick, w_restart;
  logic             r_sr_clk, r_sr_data, r_sr_latch, r_sr_oe_n, r_busy;

  assign w_restart = (w_nxt != r_state);

  gpo_sr_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_start = (r_state == IDLE) && ((bus.gpo_data != r_shipped) || r_init_pending);
    w_nxt = r_state;
    w_shadow_nxt = r_shadow;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      IDLE: if (w_start) begin
        w_nxt = CLK_LO;
        w_shadow_nxt = bus.gpo_data;
        w_bit_cnt_nxt = CNT_W'(N - 1);
      end
      CLK_LO: if (w_tick) w_nxt = CLK_HI;
      CLK_HI: if (w_tick) begin
        if (r_bit_cnt == '0) w_nxt = LATCH_HI;
        else begin
          w_nxt = CLK_LO;
          w_shadow_nxt = r_shadow << 1;
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
      LATCH_HI: if (w_tick) w_nxt = LATCH_LO;
      LATCH_LO: if (w_tick) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Pins are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow       <= '0;
      r_shipped      <= '0;
      r_bit_cnt      <= '0;
      r_init_pending <= 1'b1;
      r_sr_clk       <= 1'b0;
      r_sr_data      <= 1'b0;
      r_sr_latch     <= 1'b0;
      r_sr_oe_n      <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      r_shadow   <= w_shadow_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sr_clk   <= (w_nxt == CLK_HI);
      r_sr_data  <= ((w_nxt == CLK_LO) || (w_nxt == CLK_HI)) && w_shadow_nxt[N-1];
      r_sr_latch <= (w_nxt == LATCH_HI);
      r_busy     <= (w_nxt != IDLE);
      if (w_start) begin
        r_shipped      <= bus.gpo_data;
        r_init_pending <= 1'b0;
      end
      if ((r_state == LATCH_LO) && (w_nxt == IDLE)) r_sr_oe_n <= 1'b0;
    end
  end

  assign bus.sr_clk   = r_sr_clk;
  assign bus.sr_data  = r_sr_data;
  assign bus.sr_latch = r_sr_latch;
  assign bus.sr_oe_n  = r_sr_oe_n;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_gpo_shift_out.sv
// tb_gpo_shift_out: directed scenarios for the serial output shifter (N=32/DIV=4 and N=8/DIV=1)
module tb_gpo_shift_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpo_shift_out_if #(.N(32)) bus ();
  gpo_shift_out_if #(.N(8))  bus8 ();

  gpo_shift_out #(.N(32), .CLK_DIV(4)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  gpo_shift_out #(.N(8),  .CLK_DIV(1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;

  int          w_busy, w_rises, w_latches, w_latch_w, w_hi_bad, w_lo_bad, w_oe_low_busy;
  logic [31:0] w_cap, w_latched;
  bit          w_timeout;

  // Observes the 32-bit chain pins each cycle until busy falls, a rise count is hit, or budget runs out.
  task automatic watch(input int budget, input int stop_rises);
    logic pc, pl;
    int   run;
    bit   seen;
    w_busy = 0; w_rises = 0; w_latches = 0; w_latch_w = 0; w_hi_bad = 0; w_lo_bad = 0;
    w_oe_low_busy = 0; w_cap = '0; w_latched = '0; w_timeout = 1'b0;
    pc = bus.sr_clk; pl = bus.sr_latch; run = 0; seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        seen = 1'b1;
        w_busy++;
        if (!bus.sr_oe_n) w_oe_low_busy++;
      end
      if (bus.sr_clk !== pc) begin
        if (pc && run != 4) w_hi_bad++;
        if (!pc && w_rises > 0 && run != 4) w_lo_bad++;
        run = 1;
        if (bus.sr_clk) begin
          w_rises++;
          w_cap = {w_cap[30:0], bus.sr_data};
        end
      end else run++;
      if (bus.sr_latch) begin
        w_latch_w++;
        if (!pl) begin
          w_latches++;
          w_latched = w_cap;
        end
      end
      pl = bus.sr_latch;
      pc = bus.sr_clk;
      if (stop_rises != 0 && w_rises == stop_rises) return;
      if (seen && !bus.busy) return;
    end
    w_timeout = 1'b1;
  endtask

  task automatic test_reset();
    bus.gpo_data = 32'h0;
    bus8.gpo_data = 8'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.sr_clk !== 1'b0) begin n_bad++; $display("FAIL rst_sr_clk: got %b expected 0", bus.sr_clk); end
    n_cmp++; if (bus.sr_data !== 1'b0) begin n_bad++; $display("FAIL rst_sr_data: got %b expected 0", bus.sr_data); end
    n_cmp++; if (bus.sr_latch !== 1'b0) begin n_bad++; $display("FAIL rst_sr_latch: got %b expected 0", bus.sr_latch); end
    n_cmp++; if (bus.sr_oe_n !== 1'b1) begin n_bad++; $display("FAIL rst_sr_oe_n: got %b expected 1", bus.sr_oe_n); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    watch(400, 0);
    n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL init_timeout: busy never fell within 400 cycles"); end
    n_cmp++; if (w_busy !== 264) begin n_bad++; $display("FAIL init_busy_len: got %0d expected 264", w_busy); end
    n_cmp++; if (w_rises !== 32) begin n_bad++; $display("FAIL init_rises: got %0d expected 32", w_rises); end
    n_cmp++; if (w_cap !== 32'h0) begin n_bad++; $display("FAIL init_data: got %h expected 00000000", w_cap); end
    n_cmp++; if (w_latches !== 1) begin n_bad++; $display("FAIL init_latches: got %0d expected 1", w_latches); end
    n_cmp++; if (w_latch_w !== 4) begin n_bad++; $display("FAIL init_latch_width: got %0d expected 4", w_latch_w); end
    n_cmp++; if (w_oe_low_busy !== 0) begin n_bad++; $display("FAIL init_oe_early: got %0d busy cycles with oe_n low, expected 0", w_oe_low_busy); end
    n_cmp++; if (bus.sr_oe_n !== 1'b0) begin n_bad++; $display("FAIL init_oe_after: got %b expected 0", bus.sr_oe_n); end
  endtask

  task automatic test_pattern();
    repeat (3) @(negedge clk);
    bus.gpo_data = 32'hA500_0001;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL pat_start: got busy=%b expected 1", bus.busy); end
    watch(400, 0);
    n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL pat_timeout: busy never fell within 400 cycles"); end
    n_cmp++; if (w_busy !== 263) begin n_bad++; $display("FAIL pat_busy_len: got %0d expected 263", w_busy); end
    n_cmp++; if (w_cap !== 32'hA500_0001) begin n_bad++; $display("FAIL pat_data: got %h expected a5000001", w_cap); end
    n_cmp++; if (w_latched !== 32'hA500_0001) begin n_bad++; $display("FAIL pat_latched: got %h expected a5000001", w_latched); end
    n_cmp++; if (w_hi_bad !== 0) begin n_bad++; $display("FAIL pat_hi_phase: got %0d bad high phases expected 0", w_hi_bad); end
    n_cmp++; if (w_lo_bad !== 0) begin n_bad++; $display("FAIL pat_lo_phase: got %0d bad low phases expected 0", w_lo_bad); end
    n_cmp++; if (w_latch_w !== 4) begin n_bad++; $display("FAIL pat_latch_width: got %0d expected 4", w_latch_w); end
  endtask

  task automatic test_coalesce();
    repeat (2) @(negedge clk);
    bus.gpo_data = 32'h1;
    @(negedge clk);
    bus.gpo_data = 32'h2;
    repeat (2) @(negedge clk);
    bus.gpo_data = 32'h3;
    watch(400, 0);
    n_cmp++; if (w_latched !== 32'h1) begin n_bad++; $display("FAIL coal_first: got %h expected 00000001", w_latched); end
    watch(400, 0);
    n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL coal_follow_timeout: no follow-up transfer within 400 cycles"); end
    n_cmp++; if (w_busy !== 264) begin n_bad++; $display("FAIL coal_follow_len: got %0d expected 264", w_busy); end
    n_cmp++; if (w_latched !== 32'h3) begin n_bad++; $display("FAIL coal_follow_data: got %h expected 00000003", w_latched); end
    watch(300, 0);
    n_cmp++; if (w_busy !== 0) begin n_bad++; $display("FAIL coal_extra: got %0d busy cycles expected 0", w_busy); end
  endtask

  task automatic test_revert();
    bus.gpo_data = 32'hF0;
    @(negedge clk);
    bus.gpo_data = 32'h0F;
    @(negedge clk);
    bus.gpo_data = 32'hF0;
    watch(400, 0);
    n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL rev_timeout: busy never fell within 400 cycles"); end
    n_cmp++; if (w_latched !== 32'hF0) begin n_bad++; $display("FAIL rev_data: got %h expected 000000f0", w_latched); end
    watch(300, 0);
    n_cmp++; if (w_busy !== 0) begin n_bad++; $display("FAIL rev_extra: got %0d busy cycles expected 0", w_busy); end
  endtask

  task automatic test_reset_mid();
    bus.gpo_data = 32'hFFFF_FFFF;
    watch(400, 11);
    n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL mid_reach: bit 10 not reached within 400 cycles"); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.sr_clk !== 1'b0) begin n_bad++; $display("FAIL mid_sr_clk: got %b expected 0", bus.sr_clk); end
    n_cmp++; if (bus.sr_data !== 1'b0) begin n_bad++; $display("FAIL mid_sr_data: got %b expected 0", bus.sr_data); end
    n_cmp++; if (bus.sr_latch !== 1'b0) begin n_bad++; $display("FAIL mid_sr_latch: got %b expected 0", bus.sr_latch); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.sr_oe_n !== 1'b1) begin n_bad++; $display("FAIL mid_oe_n: got %b expected 1", bus.sr_oe_n); end
    @(negedge clk);
    rst = 1'b0;
    watch(400, 0);
    n_cmp++; if (w_busy !== 264) begin n_bad++; $display("FAIL mid_restart_len: got %0d expected 264", w_busy); end
    n_cmp++; if (w_latched !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_restart_data: got %h expected ffffffff", w_latched); end
    n_cmp++; if (w_oe_low_busy !== 0) begin n_bad++; $display("FAIL mid_oe_early: got %0d busy cycles with oe_n low, expected 0", w_oe_low_busy); end
    n_cmp++; if (bus.sr_oe_n !== 1'b0) begin n_bad++; $display("FAIL mid_oe_after: got %b expected 0", bus.sr_oe_n); end
  endtask

  task automatic test_div1();
    int       cnt, rises, tog_bad;
    logic [7:0] cap;
    logic     prev;
    bit       seen, done;
    cnt = 0; rises = 0; tog_bad = 0; cap = '0; seen = 1'b0; done = 1'b0;
    @(negedge clk);
    prev = bus8.sr_clk;
    bus8.gpo_data = 8'h81;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus8.busy) begin
        seen = 1'b1;
        cnt++;
        if (cnt >= 2 && cnt <= 16 && bus8.sr_clk === prev) tog_bad++;
      end
      if (bus8.sr_clk && !prev) begin
        rises++;
        cap = {cap[6:0], bus8.sr_data};
      end
      prev = bus8.sr_clk;
      if (seen && !bus8.busy) done = 1'b1;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL div1_timeout: busy never fell within 40 cycles"); end
    n_cmp++; if (cnt !== 18) begin n_bad++; $display("FAIL div1_len: got %0d expected 18", cnt); end
    n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL div1_rises: got %0d expected 8", rises); end
    n_cmp++; if (cap !== 8'h81) begin n_bad++; $display("FAIL div1_data: got %h expected 81", cap); end
    n_cmp++; if (tog_bad !== 0) begin n_bad++; $display("FAIL div1_toggle: got %0d non-toggling cycles expected 0", tog_bad); end
    n_cmp++; if (bus8.sr_oe_n !== 1'b0) begin n_bad++; $display("FAIL div1_oe: got %b expected 0", bus8.sr_oe_n); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_coalesce();
    test_revert();
    test_reset_mid();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpo_shift_out.md
Name: gpo_shift_out

Overview:
- Downstream stage of the general-purpose output register.
- Consumes its parallel N-bit output word and pushes it serially to an external 74HC595-style shift-register chain (data, shift clock, storage latch, output enable).
- Re-transfers automatically whenever the word differs from the last value shipped, so board-level outputs track the register without CPU involvement.

Parameters:
- N, 32, width of the output word and length of the external chain in bits.
- CLK_DIV, 4, system clocks per serial half-period; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- gpo_data  input  N  parallel output word from the output register.
- sr_clk  output  1  serial shift clock; the chain samples on its rising edge.
- sr_data  output  1  serial data, MSB first.
- sr_latch  output  1  storage-register latch; the chain transfers on its rising edge.
- sr_oe_n  output  1  active-low output enable for the chain.
- busy  output  1  high while a transfer is in progress.

Behaviour:
- Reset values (asynchronous, immediate): sr_clk=0, sr_data=0, sr_latch=0, sr_oe_n=1, busy=0, state=IDLE, shipped='0, init_pending=1.
- All pin outputs are driven directly from flops; no combinational paths to pins.
- Tick: a divider counts 0..CLK_DIV-1 and restarts at 0 on every state entry. A phase ends on the cycle the counter reaches CLK_DIV-1, so each phase lasts exactly CLK_DIV cycles.
- IDLE:
  - Start condition: gpo_data != shipped, or init_pending=1.
  - On start: shadow<=gpo_data, shipped<=gpo_data, init_pending<=0, bit_cnt<=N-1, busy<=1, go to CLK_LO.
  - Start decision uses the gpo_data value sampled in that IDLE cycle.
- CLK_LO: sr_clk=0, sr_data=shadow[N-1]; after CLK_DIV cycles go to CLK_HI.
- CLK_HI: sr_clk=1, sr_data unchanged, so data is stable across the rising edge. At phase end:
  - bit_cnt==0: go to LATCH_HI.
  - Otherwise: shadow<=shadow<<1, bit_cnt--, go to CLK_LO.
- LATCH_HI: sr_clk=0, sr_data=0, sr_latch=1 for CLK_DIV cycles, then go to LATCH_LO.
- LATCH_LO: sr_latch=0 for CLK_DIV cycles. At phase end: sr_oe_n<=0 (sticky until reset), busy<=0, go to IDLE.
- Transfer length: (2N+2)*CLK_DIV cycles from start to IDLE re-entry (N=32, CLK_DIV=4: 264 cycles). Minimum spacing between transfers is one IDLE cycle.
- gpo_data changes during a transfer:
  - Ignored mid-transfer; shadow is never reloaded.
  - Compared against shipped on IDLE re-entry, so multiple changes coalesce into one follow-up transfer carrying the newest value.
  - A change that reverts to shipped before IDLE causes no transfer.
- First transfer after reset always occurs (init_pending), even if gpo_data='0. This guarantees a defined chain state before sr_oe_n asserts.
- Reset mid-transfer: outputs return to reset values immediately; a full initial transfer restarts after release. sr_oe_n stays 1 until that transfer latches.
- Bit order: gpo_data[N-1] is shifted first; after the latch, chain stage 0 holds gpo_data[0].
- sr_oe_n never returns to 1 except on reset.

Decomposition:
- Shared package gpo_pkg:
  - sr_state_t enum {IDLE, CLK_LO, CLK_HI, LATCH_HI, LATCH_LO}.
  - Localparam DIV_W = max(1, $clog2(CLK_DIV)) helper.
- One natural sub-module, gpo_sr_tick:
  - Parameterised divider with restart input and end-of-phase tick output.
  - Reused for other serial pin drivers.
- FSM, shadow register and bit counter live in gpo_shift_out.

Test Plan:
- Reset release with gpo_data=32'h0:
  - One transfer runs: busy high 264 cycles, 32 sr_clk rising edges all with sr_data=0, one sr_latch pulse of 4 cycles.
  - sr_oe_n falls on the last LATCH_LO cycle.
- Idle then gpo_data=32'hA5000001:
  - Transfer starts next cycle.
  - Sampled sr_data on the 32 rising sr_clk edges reproduces 32'hA5000001 MSB first.
  - sr_clk high/low phases each exactly 4 cycles.
- Coalescing: during a transfer of 32'h1, write 32'h2 then 32'h3 within 10 cycles:
  - After the first latch, exactly one further transfer carrying 32'h3.
  - No transfer for 32'h2.
- Revert: during a transfer of 32'hF0, change gpo_data to 32'h0F then back to 32'hF0 before the latch:
  - busy drops, and no second transfer occurs over the next 300 cycles.
- Reset mid-transfer (assert rst at bit 10 of 32'hFFFF_FFFF):
  - sr_clk/sr_data/sr_latch/busy=0 and sr_oe_n=1 in the same cycle.
  - After release, a full 264-cycle transfer occurs, then sr_oe_n=0.
- CLK_DIV=1, N=8, gpo_data=8'h81:
  - Transfer completes in 18 cycles.
  - sr_clk toggles every cycle, and captured bits are 1,0,0,0,0,0,0,1.
